// File: rtl/dffram_2p_clr.sv
// Two-port (1W/1R) flop-based RAM with byte-lane writes, write-first
// read-during-write bypass, optional output register and a sequential
// clear engine that fills the array with CLR_VAL after reset or on CLR.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_CLEAR | clear engine writes CLR_VAL to mem[ptr]; ports blocked
// S_IDLE  | normal operation; CLR moves back to S_CLEAR with ptr=0
module dffram_2p_clr #(
  parameter int              DW      = 32,
  parameter int              AW      = 8,
  parameter int              OUT_REG = 0,
  parameter logic [DW-1:0]   CLR_VAL = '0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CLR,
  output logic            BUSY,
  input  logic [DW/8-1:0] WEN,
  input  logic [AW-1:0]   WA,
  input  logic [DW-1:0]   Di,
  input  logic            REN,
  input  logic [AW-1:0]   RA,
  output logic [DW-1:0]   Do,
  output logic            DVALID
);

  localparam int NB = DW / 8;

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            busy;

  logic [DW-1:0]   mem [2**AW];

  logic [NB-1:0]   mem_we;
  logic [AW-1:0]   mem_wa;
  logic [DW-1:0]   mem_wd;

  logic            rd_fire;
  logic [DW-1:0]   rd_word;

  logic [DW-1:0]   do1_q, do1_d;
  logic            dv1_q, dv1_d;

  // FSM state and clear pointer register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM next state: clear walks the whole array once, CLR in idle restarts it
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == {AW{1'b1}}) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (CLR) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == S_CLEAR);
    BUSY = busy;
  end

  // Write port mux: clear engine owns the array while busy
  always_comb begin
    if (busy) begin
      mem_we = '1;
      mem_wa = ptr_q;
      mem_wd = CLR_VAL;
    end else begin
      mem_we = WEN;
      mem_wa = WA;
      mem_wd = Di;
    end
  end

  // Storage array; deliberately not reset, the clear engine initialises it
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we[i]) mem[mem_wa][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  // Read data with per-lane write-first bypass on an address match
  always_comb begin
    rd_fire = REN && !busy;
    rd_word = mem[RA];
    for (int i = 0; i < NB; i++) begin
      if (WEN[i] && (WA == RA)) rd_word[8*i +: 8] = Di[8*i +: 8];
    end
    do1_d = rd_fire ? rd_word : do1_q;
    dv1_d = rd_fire;
  end

  // First read stage register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      do1_q <= '0;
      dv1_q <= 1'b0;
    end else begin
      do1_q <= do1_d;
      dv1_q <= dv1_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DW-1:0] do2_q, do2_d;
      logic          dv2_q, dv2_d;

      // Second stage follows the first regardless of busy so in-flight reads finish
      always_comb begin
        do2_d = dv1_q ? do1_q : do2_q;
        dv2_d = dv1_q;
      end

      // Output pipeline register
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          do2_q <= '0;
          dv2_q <= 1'b0;
        end else begin
          do2_q <= do2_d;
          dv2_q <= dv2_d;
        end
      end

      assign Do     = do2_q;
      assign DVALID = dv2_q;
    end else begin : g_no_out_reg
      assign Do     = do1_q;
      assign DVALID = dv1_q;
    end
  endgenerate

endmodule

// File: tb/tb_dffram_2p_clr.sv
module tb_dffram_2p_clr;

  localparam logic [31:0] CV = 32'hDEADBEEF;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CLR;
  logic [3:0]  WEN;
  logic [3:0]  WA;
  logic [31:0] Di;
  logic        REN;
  logic [3:0]  RA;

  logic        busy0, dv0, busy1, dv1;
  logic [31:0] do0, do1;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  dffram_2p_clr #(.DW(32), .AW(4), .OUT_REG(0), .CLR_VAL(CV)) u0 (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .BUSY(busy0), .WEN(WEN), .WA(WA),
    .Di(Di), .REN(REN), .RA(RA), .Do(do0), .DVALID(dv0));

  dffram_2p_clr #(.DW(32), .AW(4), .OUT_REG(1), .CLR_VAL(CV)) u1 (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .BUSY(busy1), .WEN(WEN), .WA(WA),
    .Di(Di), .REN(REN), .RA(RA), .Do(do1), .DVALID(dv1));

  typedef struct {
    logic [3:0]  wen;
    logic [3:0]  wa;
    logic [31:0] di;
    logic        ren;
    logic [3:0]  ra;
    logic [31:0] exp_do;
    logic        exp_dv;
  } vec_t;

  vec_t vec [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    CLR = 1'b0; WEN = '0; WA = '0; Di = '0; REN = 1'b0; RA = '0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy0 && n < 100) begin
      step();
      n++;
    end
  endtask

  int n;

  initial begin
    vec[0]  = '{4'hF, 4'd3, 32'h11223344, 1'b0, 4'd0, CV,           1'b0};
    vec[1]  = '{4'h5, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0, CV,           1'b0};
    vec[2]  = '{4'h0, 4'd0, 32'h0,        1'b1, 4'd3, 32'h11BB33DD, 1'b1};
    vec[3]  = '{4'h0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h11BB33DD, 1'b0};
    vec[4]  = '{4'hF, 4'd5, 32'h0,        1'b0, 4'd0, 32'h11BB33DD, 1'b0};
    vec[5]  = '{4'h3, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5, 32'h0000FFFF, 1'b1};
    vec[6]  = '{4'h0, 4'd0, 32'h0,        1'b1, 4'd5, 32'h0000FFFF, 1'b1};
    vec[7]  = '{4'h0, 4'd0, 32'h0,        1'b1, 4'd4, CV,           1'b1};
    vec[8]  = '{4'hF, 4'd1, 32'd10,       1'b0, 4'd0, CV,           1'b0};
    vec[9]  = '{4'hF, 4'd2, 32'd20,       1'b0, 4'd0, CV,           1'b0};
    vec[10] = '{4'hF, 4'd3, 32'd30,       1'b0, 4'd0, CV,           1'b0};
    vec[11] = '{4'hF, 4'd6, 32'h12345678, 1'b1, 4'd6, 32'h12345678, 1'b1};

    // reset state
    RST_N = 1'b0;
    idle_inputs();
    repeat (3) step();
    check("rst_do", do0, 32'h0);
    check("rst_dv", {31'b0, dv0}, 32'h0);
    check("rst_busy", {31'b0, busy0}, 32'h1);
    RST_N = 1'b1;
    wait_idle(n);
    check("rst_clear_cycles", n, 16);

    // every word holds the clear value, latency 1
    for (int i = 0; i < 16; i++) begin
      REN = 1'b1; RA = 4'(i);
      step();
      check($sformatf("clr_rd%0d_do", i), do0, CV);
      check($sformatf("clr_rd%0d_dv", i), {31'b0, dv0}, 32'h1);
    end
    idle_inputs();

    // directed vector table
    for (int i = 0; i < 12; i++) begin
      WEN = vec[i].wen; WA = vec[i].wa; Di = vec[i].di;
      REN = vec[i].ren; RA = vec[i].ra;
      step();
      check($sformatf("vec%0d_do", i), do0, vec[i].exp_do);
      check($sformatf("vec%0d_dv", i), {31'b0, dv0}, {31'b0, vec[i].exp_dv});
    end
    idle_inputs();
    step();

    // OUT_REG=1 back-to-back reads of 1,2,3
    REN = 1'b1; RA = 4'd1;
    step();
    check("or_e1_dv1", {31'b0, dv1}, 32'h0);
    check("or_e1_do0", do0, 32'd10);
    RA = 4'd2;
    step();
    check("or_e2_do1", do1, 32'd10);
    check("or_e2_dv1", {31'b0, dv1}, 32'h1);
    RA = 4'd3;
    step();
    check("or_e3_do1", do1, 32'd20);
    check("or_e3_dv1", {31'b0, dv1}, 32'h1);
    idle_inputs();
    step();
    check("or_e4_do1", do1, 32'd30);
    check("or_e4_dv1", {31'b0, dv1}, 32'h1);
    step();
    check("or_e5_do1", do1, 32'd30);
    check("or_e5_dv1", {31'b0, dv1}, 32'h0);

    // CLR in idle with a write and a read in the same cycle
    CLR = 1'b1; WEN = 4'hF; WA = 4'd7; Di = 32'h77777777; REN = 1'b1; RA = 4'd2;
    step();
    check("clr_busy", {31'b0, busy0}, 32'h1);
    check("clr_rd_do", do0, 32'd20);
    check("clr_rd_dv", {31'b0, dv0}, 32'h1);
    CLR = 1'b0; WEN = 4'hF; WA = 4'd8; Di = 32'hAAAAAAAA; REN = 1'b1; RA = 4'd3;
    step();
    check("busy_rd_dv", {31'b0, dv0}, 32'h0);
    check("busy_rd_do", do0, 32'd20);
    check("busy_pipe_dv1", {31'b0, dv1}, 32'h1);
    check("busy_pipe_do1", do1, 32'd20);
    idle_inputs();
    wait_idle(n);
    check("clr_cycles", n + 1, 16);
    REN = 1'b1; RA = 4'd7;
    step();
    check("after_clr_a7", do0, CV);
    RA = 4'd1;
    step();
    check("after_clr_a1", do0, CV);
    check("after_clr_a1_dv", {31'b0, dv0}, 32'h1);
    idle_inputs();

    // async reset part-way through a clear (ptr = 6)
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    repeat (6) step();
    check("mid_busy", {31'b0, busy0}, 32'h1);
    #2;
    RST_N = 1'b0;
    #1;
    check("mid_rst_do0", do0, 32'h0);
    check("mid_rst_dv0", {31'b0, dv0}, 32'h0);
    check("mid_rst_do1", do1, 32'h0);
    step();
    RST_N = 1'b1;
    wait_idle(n);
    check("mid_rst_clear_cycles", n, 16);
    REN = 1'b1; RA = 4'd9;
    step();
    check("final_rd_do", do0, CV);
    check("final_rd_dv", {31'b0, dv0}, 32'h1);
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
